// File: rtl/dff_test_pkg.sv
// rtl/dff_test_pkg.sv - shared constants, FSM state type and helpers for the DFF error counter
package dff_test_pkg;

  localparam int NUM_CHAINS = 14;
  localparam int CNT_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping back to zero
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/dff_error_counter_if.sv
// rtl/dff_error_counter_if.sv - signal bundle between the chain test harness and the error counter
interface dff_error_counter_if;
  import dff_test_pkg::*;

  logic                  start;
  logic                  stop;
  logic [NUM_CHAINS-1:0] chain_out;
  logic                  pattern_in;
  logic                  save_data;
  logic                  busy;
  logic [CNT_W-1:0]      dff_error [NUM_CHAINS];

  modport master (
    output start, stop, chain_out,
    input  pattern_in, save_data, busy, dff_error
  );

  modport slave (
    input  start, stop, chain_out,
    output pattern_in, save_data, busy, dff_error
  );

endinterface

// File: rtl/dff_err_cnt_sat.sv
// rtl/dff_err_cnt_sat.sv - one saturating error counter with synchronous clear and increment
module dff_err_cnt_sat
  import dff_test_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count_next
);

  logic [CNT_W-1:0] count;

  // Next value is exported so a snapshot can capture this cycle's increment
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (inc) begin
      count_next = sat_inc(count);
    end
  end

  // Counter register, cleared by the active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/dff_error_counter.sv
// rtl/dff_error_counter.sv - drives a toggle pattern into 14 DFF chains and counts per-chain mismatches
module dff_error_counter
  import dff_test_pkg::*;
#(
  parameter int CHAIN_LEN     = 64,
  parameter int SAVE_INTERVAL = 1000000,
  parameter int SAVE_PULSE    = 4
) (
  input  logic                  data_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [NUM_CHAINS-1:0] chain_out,
  output logic                  pattern_in,
  output logic [CNT_W-1:0]      DFF_ERROR_0,
  output logic [CNT_W-1:0]      DFF_ERROR_1,
  output logic [CNT_W-1:0]      DFF_ERROR_2,
  output logic [CNT_W-1:0]      DFF_ERROR_3,
  output logic [CNT_W-1:0]      DFF_ERROR_4,
  output logic [CNT_W-1:0]      DFF_ERROR_5,
  output logic [CNT_W-1:0]      DFF_ERROR_6,
  output logic [CNT_W-1:0]      DFF_ERROR_7,
  output logic [CNT_W-1:0]      DFF_ERROR_8,
  output logic [CNT_W-1:0]      DFF_ERROR_9,
  output logic [CNT_W-1:0]      DFF_ERROR_10,
  output logic [CNT_W-1:0]      DFF_ERROR_11,
  output logic [CNT_W-1:0]      DFF_ERROR_12,
  output logic [CNT_W-1:0]      DFF_ERROR_13,
  output logic                  save_data,
  output logic                  busy
);

  localparam int FILL_W = $clog2(CHAIN_LEN + 1);
  localparam int INT_W  = $clog2(SAVE_INTERVAL);

  localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(CHAIN_LEN);
  localparam logic [INT_W-1:0]  INT_LAST   = INT_W'(SAVE_INTERVAL - 1);
  localparam logic [7:0]        PULSE_LAST = 8'(SAVE_PULSE - 1);

  state_t                state;
  state_t                state_next;
  logic [FILL_W-1:0]     fill_cnt;
  logic [INT_W-1:0]      interval_cnt;
  logic [NUM_CHAINS-1:0] chain_q;
  logic [CHAIN_LEN:0]    exp_sr;
  logic                  expected;
  logic                  cnt_clear;
  logic [NUM_CHAINS-1:0] cnt_inc;
  logic                  interval_wrap;
  logic                  pulse_active;
  logic                  snap_trig;
  logic                  pulse_pend;
  logic [7:0]            pulse_left;
  logic [CNT_W-1:0]      live_next [NUM_CHAINS];
  logic [CNT_W-1:0]      snap      [NUM_CHAINS];

  // The reference bit is the pattern as it left CHAIN_LEN+1 cycles ago
  assign expected = exp_sr[CHAIN_LEN];

  // Next state plus the per-cycle strobes that depend on the current state
  always_comb begin
    state_next    = state;
    cnt_clear     = 1'b0;
    cnt_inc       = '0;
    interval_wrap = 1'b0;
    pulse_active  = pulse_pend | save_data;
    snap_trig     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FILL;
          cnt_clear  = 1'b1;
        end
      end
      ST_FILL: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (fill_cnt == FILL_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_inc       = chain_q ^ {NUM_CHAINS{expected}};
        interval_wrap = (interval_cnt == INT_LAST);
        // A stop takes a final snapshot unless one is already being reported
        snap_trig     = interval_wrap | (stop & ~pulse_active);
        if (stop) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register with busy, pattern and the fill/interval counters that follow it
  always_ff @(posedge data_clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      pattern_in   <= 1'b0;
      fill_cnt     <= '0;
      interval_cnt <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      if (state_next == ST_IDLE) begin
        pattern_in <= 1'b0;
      end else if (state == ST_IDLE) begin
        pattern_in <= 1'b1;
      end else begin
        pattern_in <= ~pattern_in;
      end
      fill_cnt     <= (state == ST_FILL && state_next == ST_FILL) ? fill_cnt + 1'b1 : '0;
      interval_cnt <= (state == ST_RUN && state_next == ST_RUN && !interval_wrap)
                      ? interval_cnt + 1'b1 : '0;
    end
  end

  // Chain capture and the pattern delay line used as the reference
  always_ff @(posedge data_clk) begin
    if (!reset) begin
      chain_q <= '0;
      exp_sr  <= '0;
    end else begin
      chain_q <= chain_out;
      exp_sr  <= {exp_sr[CHAIN_LEN-1:0], pattern_in};
    end
  end

  // Snapshot registers hold the live counts taken on each trigger
  always_ff @(posedge data_clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHAINS; i++) begin
        snap[i] <= '0;
      end
    end else if (snap_trig) begin
      for (int i = 0; i < NUM_CHAINS; i++) begin
        snap[i] <= live_next[i];
      end
    end
  end

  // save_data strobe: starts the edge after a trigger and runs its full length regardless of state
  always_ff @(posedge data_clk) begin
    if (!reset) begin
      pulse_pend <= 1'b0;
      save_data  <= 1'b0;
      pulse_left <= '0;
    end else begin
      pulse_pend <= snap_trig;
      if (pulse_pend) begin
        save_data  <= 1'b1;
        pulse_left <= PULSE_LAST;
      end else if (save_data) begin
        if (pulse_left == 8'd0) begin
          save_data <= 1'b0;
        end else begin
          pulse_left <= pulse_left - 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_chain
    dff_err_cnt_sat u_cnt (
      .clk        (data_clk),
      .reset      (reset),
      .clear      (cnt_clear),
      .inc        (cnt_inc[i]),
      .count_next (live_next[i])
    );
  end

  assign DFF_ERROR_0  = snap[0];
  assign DFF_ERROR_1  = snap[1];
  assign DFF_ERROR_2  = snap[2];
  assign DFF_ERROR_3  = snap[3];
  assign DFF_ERROR_4  = snap[4];
  assign DFF_ERROR_5  = snap[5];
  assign DFF_ERROR_6  = snap[6];
  assign DFF_ERROR_7  = snap[7];
  assign DFF_ERROR_8  = snap[8];
  assign DFF_ERROR_9  = snap[9];
  assign DFF_ERROR_10 = snap[10];
  assign DFF_ERROR_11 = snap[11];
  assign DFF_ERROR_12 = snap[12];
  assign DFF_ERROR_13 = snap[13];

endmodule

// File: tb/tb_dff_error_counter.sv
// tb/tb_dff_error_counter.sv - self-checking bench for dff_error_counter
module tb_dff_error_counter;
  import dff_test_pkg::*;

  localparam int CL = 4;
  localparam int SI = 32;
  localparam int SP = 4;
  localparam longint MAXV = 64'h00000000FFFFFFFF;

  logic data_clk = 1'b0;
  logic reset;
  dff_error_counter_if bus();

  always #5 data_clk = ~data_clk;

  dff_error_counter #(.CHAIN_LEN(CL), .SAVE_INTERVAL(SI), .SAVE_PULSE(SP)) dut (
    .data_clk     (data_clk),
    .reset        (reset),
    .start        (bus.start),
    .stop         (bus.stop),
    .chain_out    (bus.chain_out),
    .pattern_in   (bus.pattern_in),
    .DFF_ERROR_0  (bus.dff_error[0]),
    .DFF_ERROR_1  (bus.dff_error[1]),
    .DFF_ERROR_2  (bus.dff_error[2]),
    .DFF_ERROR_3  (bus.dff_error[3]),
    .DFF_ERROR_4  (bus.dff_error[4]),
    .DFF_ERROR_5  (bus.dff_error[5]),
    .DFF_ERROR_6  (bus.dff_error[6]),
    .DFF_ERROR_7  (bus.dff_error[7]),
    .DFF_ERROR_8  (bus.dff_error[8]),
    .DFF_ERROR_9  (bus.dff_error[9]),
    .DFF_ERROR_10 (bus.dff_error[10]),
    .DFF_ERROR_11 (bus.dff_error[11]),
    .DFF_ERROR_12 (bus.dff_error[12]),
    .DFF_ERROR_13 (bus.dff_error[13]),
    .save_data    (bus.save_data),
    .busy         (bus.busy)
  );

  int checks = 0;
  int errors = 0;

  // physical chain emulation: delay line plus fault masks
  logic                  ph [0:CL];
  logic [NUM_CHAINS-1:0] f_s0, f_s1, f_inv, f_noise;

  // behavioural reference model
  int                    m_mode;   // 0 idle, 1 fill, 2 run
  int                    m_tcyc;   // cycle index since the test started
  int                    m_run;    // RUN cycle index
  longint                m_live [NUM_CHAINS];
  logic [31:0]           m_snap [NUM_CHAINS];
  logic                  m_pend;
  int                    m_left;
  logic [NUM_CHAINS-1:0] m_cq;

  typedef struct {
    logic r, st, sp;
    logic busy, pat, save;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic st, input logic sp,
                            input logic [NUM_CHAINS-1:0] co);
    logic [NUM_CHAINS-1:0] cq;
    logic ex, trig, active;
    if (!r) begin
      m_mode = 0; m_tcyc = 0; m_run = 0; m_pend = 1'b0; m_left = 0; m_cq = '0;
      for (int n = 0; n < NUM_CHAINS; n++) begin
        m_live[n] = 0;
        m_snap[n] = '0;
      end
      return;
    end
    cq = m_cq;
    m_cq = co;
    trig = 1'b0;
    active = m_pend || (m_left > 0);
    case (m_mode)
      0: if (st) begin
        m_mode = 1; m_tcyc = 0;
        for (int n = 0; n < NUM_CHAINS; n++) m_live[n] = 0;
      end
      1: if (sp) m_mode = 0;
         else begin
           if (m_tcyc == CL) begin m_mode = 2; m_run = 0; end
           m_tcyc++;
         end
      default: begin
        ex = (m_run % 2 == 0);
        for (int n = 0; n < NUM_CHAINS; n++)
          if (cq[n] != ex && m_live[n] < MAXV) m_live[n]++;
        if (m_run % SI == SI - 1) trig = 1'b1;
        if (sp) begin
          if (!active) trig = 1'b1;
          m_mode = 0;
        end else begin
          m_run++; m_tcyc++;
        end
      end
    endcase
    if (m_left > 0) m_left--;
    if (m_pend) m_left = SP;
    m_pend = trig;
    if (trig)
      for (int n = 0; n < NUM_CHAINS; n++) m_snap[n] = 32'(m_live[n]);
  endtask

  task automatic model_check();
    logic pat;
    pat = (m_mode != 0) ? (m_tcyc % 2 == 0) : 1'b0;
    chk("pattern_in", 32'(bus.pattern_in), 32'(pat));
    chk("busy", 32'(bus.busy), 32'(m_mode != 0));
    chk("save_data", 32'(bus.save_data), 32'(m_left > 0));
    for (int n = 0; n < NUM_CHAINS; n++)
      chk($sformatf("dff_error_%0d", n), bus.dff_error[n], m_snap[n]);
  endtask

  task automatic cycle(input logic r, input logic st, input logic sp);
    logic [NUM_CHAINS-1:0] co;
    for (int n = 0; n < NUM_CHAINS; n++)
      co[n] = f_s0[n] ? 1'b0 : f_s1[n] ? 1'b1 : (ph[CL] ^ f_inv[n] ^ f_noise[n]);
    reset = r; bus.start = st; bus.stop = sp; bus.chain_out = co;
    @(posedge data_clk);
    model_step(r, st, sp, co);
    @(negedge data_clk);
    for (int i = CL; i > 0; i--) ph[i] = ph[i-1];
    ph[0] = bus.pattern_in;
    model_check();
  endtask

  task automatic clear_faults();
    f_s0 = '0; f_s1 = '0; f_inv = '0; f_noise = '0;
  endtask

  // reset, start, then idle through FILL so the next cycle() call is RUN cycle 0
  task automatic start_test();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < CL + 1; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int rises, high;
    logic prev, r, st, sp;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i <= CL; i++) ph[i] = 1'b0;
    clear_faults();
    reset = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.chain_out = '0;
    @(negedge data_clk);

    // control sequence table: idle hold, start+stop, FILL length, stop with final pulse
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].r, tbl[i].st, tbl[i].sp);
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_pattern", i), 32'(bus.pattern_in), 32'(tbl[i].pat));
      chk($sformatf("vec%0d_save", i), 32'(bus.save_data), 32'(tbl[i].save));
      chk($sformatf("vec%0d_err0", i), bus.dff_error[0], 32'd0);
    end

    // clean chains, start held 100 RUN cycles
    clear_faults();
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CL + 2; i++) cycle(1'b1, 1'b1, 1'b0);
    rises = 0; high = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (bus.save_data && !prev) rises++;
      if (bus.save_data) high++;
      prev = bus.save_data;
    end
    chk("clean_pulse_count", 32'(rises), 32'd3);
    chk("clean_pulse_cycles", 32'(high), 32'd12);
    for (int n = 0; n < NUM_CHAINS; n++)
      chk($sformatf("clean_err%0d", n), bus.dff_error[n], 32'd0);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);

    // chain 5 stuck at 0
    clear_faults();
    f_s0 = 14'(1 << 5);
    start_test();
    for (int i = 0; i < SI; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("stuck5_first", bus.dff_error[5], 32'd16);
    chk("stuck5_other0", bus.dff_error[0], 32'd0);
    chk("stuck5_other13", bus.dff_error[13], 32'd0);
    for (int i = 0; i < SI; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("stuck5_second", bus.dff_error[5], 32'd32);
    chk("stuck5_other4", bus.dff_error[4], 32'd0);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);

    // chain 3 inverted with the live counter preloaded near saturation
    clear_faults();
    f_inv = 14'(1 << 3);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    force dut.g_chain[3].u_cnt.count = 32'hFFFFFFFE;
    m_live[3] = 64'h00000000FFFFFFFE;
    cycle(1'b1, 1'b0, 1'b0);
    release dut.g_chain[3].u_cnt.count;
    for (int i = 0; i < CL - 1; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < SI; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("sat3_first", bus.dff_error[3], 32'hFFFFFFFF);
    for (int i = 0; i < SI; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk("sat3_nonzero", 32'(bus.dff_error[3] != 32'd0), 32'd1);
    end
    chk("sat3_second", bus.dff_error[3], 32'hFFFFFFFF);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);

    // stop in the 10th RUN cycle: final snapshot and pulse
    clear_faults();
    f_s0 = 14'(1 << 5);
    f_s1 = 14'(1 << 7);
    start_test();
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_err5", bus.dff_error[5], 32'd5);
    chk("stop_err7", bus.dff_error[7], 32'd5);
    chk("stop_err0", bus.dff_error[0], 32'd0);
    chk("stop_save_low", 32'(bus.save_data), 32'd0);
    for (int i = 0; i < SP; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk("stop_save_high", 32'(bus.save_data), 32'd1);
    end
    cycle(1'b1, 1'b0, 1'b0);
    chk("stop_save_end", 32'(bus.save_data), 32'd0);

    // reset while save_data is high
    clear_faults();
    f_s0 = 14'(1 << 2);
    start_test();
    for (int i = 0; i < SI + 2; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("rst_save_before", 32'(bus.save_data), 32'd1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("rst_save", 32'(bus.save_data), 32'd0);
    chk("rst_pattern", 32'(bus.pattern_in), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst_err2", bus.dff_error[2], 32'd0);

    // randomized control and chain faults against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        f_s0  = 14'($urandom & $urandom & $urandom);
        f_s1  = 14'($urandom & $urandom & $urandom);
        f_inv = 14'($urandom & $urandom & $urandom);
      end
      f_noise = ($urandom_range(0, 15) == 0) ? 14'(1 << $urandom_range(0, 13)) : '0;
      r  = ($urandom_range(0, 599) != 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 79) == 0);
      cycle(r, st, sp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
